// File: rtl/leaf_nn_search.sv
// Leaf nearest-neighbour search: streams the LEAF_SIZE candidates of one leaf
// through a two-stage distance/compare pipeline and offers the nearest one as a result.
module leaf_nn_search #(
  parameter int DATA_WIDTH    = 11,
  parameter int DIM           = 5,
  parameter int PATCH_WIDTH   = DATA_WIDTH * DIM,
  parameter int ADDRESS_WIDTH = 8,
  parameter int LEAF_SIZE     = 8,
  parameter int IDX_WIDTH     = 3,
  parameter int DIST_WIDTH    = 25
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           leaf_en,
  input  logic [ADDRESS_WIDTH-1:0]       leaf_index,
  input  logic [PATCH_WIDTH-1:0]         query_patch,
  output logic                           busy,
  output logic                           mem_ren,
  output logic [ADDRESS_WIDTH+IDX_WIDTH-1:0] mem_addr,
  input  logic [PATCH_WIDTH-1:0]         mem_rdata,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [DIST_WIDTH-1:0]          best_dist,
  output logic [ADDRESS_WIDTH+IDX_WIDTH-1:0] best_addr,
  output logic [1:0]                     dbg_state
);

  // Result handshake: result_valid stays high with stable best_dist/best_addr
  // until an edge sees result_ready=1; that edge completes the transfer.
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESULT} state_t;

  localparam int SQ_WIDTH = 2 * DATA_WIDTH;

  state_t                            state_q;
  logic [ADDRESS_WIDTH-1:0]          leaf_q;
  logic [PATCH_WIDTH-1:0]            query_q;
  logic [IDX_WIDTH-1:0]              j_q;
  logic                              mem_ren_q;
  logic [ADDRESS_WIDTH+IDX_WIDTH-1:0] mem_addr_q;
  logic                              rd_valid_q;
  logic [IDX_WIDTH-1:0]              rd_idx_q;
  logic                              a_valid_q;
  logic [IDX_WIDTH-1:0]              a_idx_q;
  logic [DIST_WIDTH-1:0]             a_dist_q;
  logic [DIST_WIDTH-1:0]             best_dist_q;
  logic [ADDRESS_WIDTH+IDX_WIDTH-1:0] best_addr_q;
  logic                              result_valid_q;
  logic [DIST_WIDTH-1:0]             dist_d;
  logic [SQ_WIDTH-1:0]               sq [DIM];

  // The squared difference is non-negative and below 2^SQ_WIDTH, so the low
  // SQ_WIDTH bits of a SQ_WIDTH-wide product are exact.
  for (genvar g = 0; g < DIM; g++) begin : g_comp
    logic [DATA_WIDTH-1:0] q_c;
    logic [DATA_WIDTH-1:0] m_c;
    logic [DATA_WIDTH:0]   diff;
    logic [SQ_WIDTH-1:0]   diff_ext;
    assign q_c      = query_q[DATA_WIDTH*g +: DATA_WIDTH];
    assign m_c      = mem_rdata[DATA_WIDTH*g +: DATA_WIDTH];
    assign diff     = {q_c[DATA_WIDTH-1], q_c} - {m_c[DATA_WIDTH-1], m_c};
    assign diff_ext = {{(SQ_WIDTH-DATA_WIDTH-1){diff[DATA_WIDTH]}}, diff};
    assign sq[g]    = diff_ext * diff_ext;
  end

  always_comb begin
    dist_d = '0;
    for (int i = 0; i < DIM; i++) begin
      dist_d = dist_d + DIST_WIDTH'(sq[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      leaf_q         <= '0;
      query_q        <= '0;
      j_q            <= '0;
      mem_ren_q      <= 1'b0;
      mem_addr_q     <= '0;
      rd_valid_q     <= 1'b0;
      rd_idx_q       <= '0;
      a_valid_q      <= 1'b0;
      a_idx_q        <= '0;
      a_dist_q       <= '0;
      best_dist_q    <= '0;
      best_addr_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      // Read data returns one cycle after issue; stage A registers its distance.
      rd_valid_q <= mem_ren_q;
      rd_idx_q   <= j_q;
      a_valid_q  <= rd_valid_q;
      a_idx_q    <= rd_idx_q;
      a_dist_q   <= dist_d;

      // Stage B: strict less-than keeps the lowest index on ties.
      if (a_valid_q && ((a_idx_q == '0) || (a_dist_q < best_dist_q))) begin
        best_dist_q <= a_dist_q;
        best_addr_q <= {leaf_q, a_idx_q};
      end

      case (state_q)
        IDLE: begin
          if (leaf_en) begin
            leaf_q     <= leaf_index;
            query_q    <= query_patch;
            j_q        <= '0;
            mem_ren_q  <= 1'b1;
            mem_addr_q <= {leaf_index, {IDX_WIDTH{1'b0}}};
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (j_q == IDX_WIDTH'(LEAF_SIZE - 1)) begin
            mem_ren_q <= 1'b0;
            state_q   <= DRAIN;
          end else begin
            j_q        <= j_q + IDX_WIDTH'(1);
            mem_addr_q <= {leaf_q, j_q + IDX_WIDTH'(1)};
          end
        end
        DRAIN: begin
          if (a_valid_q && (a_idx_q == IDX_WIDTH'(LEAF_SIZE - 1))) begin
            result_valid_q <= 1'b1;
            state_q        <= RESULT;
          end
        end
        RESULT: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign mem_ren      = mem_ren_q;
  assign mem_addr     = mem_addr_q;
  assign result_valid = result_valid_q;
  assign best_dist    = best_dist_q;
  assign best_addr    = best_addr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_leaf_nn_search.sv
// Directed and randomized searches of leaf_nn_search against a behavioural
// nearest-neighbour model built from plain integer arithmetic.
module tb_leaf_nn_search;

  localparam int DW  = 11;
  localparam int DIM = 5;
  localparam int PW  = 55;
  localparam int AW  = 8;
  localparam int LS  = 8;
  localparam int IW  = 3;
  localparam int DSW = 25;
  localparam int NMEM = 1 << (AW + IW);

  logic              clk;
  logic              rst_n;
  logic              leaf_en;
  logic [AW-1:0]     leaf_index;
  logic [PW-1:0]     query_patch;
  logic              busy;
  logic              mem_ren;
  logic [AW+IW-1:0]  mem_addr;
  logic [PW-1:0]     mem_rdata;
  logic              result_valid;
  logic              result_ready;
  logic [DSW-1:0]    best_dist;
  logic [AW+IW-1:0]  best_addr;
  logic [1:0]        dbg_state;

  int n_checks;
  int n_fails;
  int cand [NMEM][DIM];
  logic [PW-1:0] mem [NMEM];
  int qv [DIM];
  int c_tmp [DIM];

  leaf_nn_search dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .leaf_en      (leaf_en),
    .leaf_index   (leaf_index),
    .query_patch  (query_patch),
    .busy         (busy),
    .mem_ren      (mem_ren),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .best_dist    (best_dist),
    .best_addr    (best_addr),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaf patch memory: one-cycle read latency
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
    else         mem_rdata <= '0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_comp();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic set_entry(input int addr);
    for (int i = 0; i < DIM; i++) begin
      cand[addr][i] = c_tmp[i];
      mem[addr][DW*i +: DW] = c_tmp[i][DW-1:0];
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ren"}, mem_ren, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_dist"}, best_dist, 0);
    check({tag, "_baddr"}, best_addr, 0);
  endtask

  // Full search with cycle-exact checks; wait_cycles>0 holds result_ready low.
  task automatic run_search(input int leaf, input int wait_cycles, input string tag);
    longint exp_d;
    int     exp_a;
    exp_d = 0;
    exp_a = 0;
    for (int j = 0; j < LS; j++) begin
      longint d;
      d = 0;
      for (int i = 0; i < DIM; i++) begin
        longint df;
        df = longint'(qv[i]) - longint'(cand[leaf*LS + j][i]);
        d += df * df;
      end
      if (j == 0 || d < exp_d) begin
        exp_d = d;
        exp_a = leaf * LS + j;
      end
    end
    for (int i = 0; i < DIM; i++) query_patch[DW*i +: DW] = qv[i][DW-1:0];
    leaf_index   = AW'(leaf);
    leaf_en      = 1'b1;
    result_ready = (wait_cycles == 0);
    step();
    leaf_en     = 1'b0;
    query_patch = '0;
    for (int c = 1; c <= LS; c++) begin
      check({tag, "_ren"}, mem_ren, 1);
      check({tag, "_addr"}, mem_addr, leaf * LS + c - 1);
      check({tag, "_busy"}, busy, 1);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      check({tag, "_ren_off"}, mem_ren, 0);
      check({tag, "_rv_early"}, result_valid, 0);
      step();
    end
    check({tag, "_rv"}, result_valid, 1);
    check({tag, "_dist"}, best_dist, exp_d);
    check({tag, "_baddr"}, best_addr, exp_a);
    if (wait_cycles > 0) begin
      for (int k = 0; k < wait_cycles; k++) begin
        leaf_en    = (k == 2);
        leaf_index = ~AW'(leaf);
        step();
        check({tag, "_bp_rv"}, result_valid, 1);
        check({tag, "_bp_busy"}, busy, 1);
        check({tag, "_bp_ren"}, mem_ren, 0);
        check({tag, "_bp_dist"}, best_dist, exp_d);
        check({tag, "_bp_baddr"}, best_addr, exp_a);
      end
      result_ready = 1'b1;
      leaf_en      = 1'b1;
      step();
      leaf_en = 1'b0;
    end else begin
      step();
    end
    check({tag, "_rv_drop"}, result_valid, 0);
    check({tag, "_idle"}, busy, 0);
    step();
    check({tag, "_idle_hold"}, busy, 0);
    check({tag, "_hold_dist"}, best_dist, exp_d);
    check({tag, "_hold_baddr"}, best_addr, exp_a);
  endtask

  task automatic setup_exact_match();
    qv = '{251, -26, -1, -88, 79};
    for (int j = 0; j < LS; j++) begin
      c_tmp = qv;
      if (j != 3) c_tmp[0] = qv[0] + 5;
      set_entry(59 * LS + j);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst_n        = 1'b0;
    leaf_en      = 1'b1;
    leaf_index   = 8'd17;
    query_patch  = '1;
    result_ready = 1'b0;
    for (int a = 0; a < NMEM; a++) mem[a] = '0;

    // Reset held with leaf_en asserted
    for (int k = 0; k < 3; k++) begin
      step();
      check_zero_outputs("reset");
    end
    leaf_en = 1'b0;
    rst_n   = 1'b1;
    step();
    check("reset_no_accept", busy, 0);

    // Exact match at j=3
    setup_exact_match();
    run_search(59, 0, "exact");

    // Extremes: every candidate at maximum distance, tie resolves to j=0
    begin
      int leaf;
      leaf = int'($urandom_range(0, 255));
      qv = '{-1024, -1024, -1024, -1024, -1024};
      c_tmp = '{1023, 1023, 1023, 1023, 1023};
      for (int j = 0; j < LS; j++) set_entry(leaf * LS + j);
      run_search(leaf, 0, "extreme");
      check("extreme_const_dist", best_dist, 20951045);
      check("extreme_const_addr", best_addr, leaf * LS);
    end

    // Tie ordering: j=2 and j=5 both at distance 4
    for (int i = 0; i < DIM; i++) qv[i] = int'($urandom_range(0, 2000)) - 1000;
    for (int j = 0; j < LS; j++) begin
      c_tmp = qv;
      if (j == 2)      c_tmp[1] = qv[1] + 2;
      else if (j == 5) c_tmp[3] = qv[3] - 2;
      else             c_tmp[0] = qv[0] + 10;
      set_entry(5 * LS + j);
    end
    run_search(5, 0, "tie");
    check("tie_const_dist", best_dist, 4);
    check("tie_const_addr", best_addr, 42);

    // Backpressure on a random leaf, then an immediate follow-up search
    begin
      int leaf;
      leaf = int'($urandom_range(0, 255));
      for (int i = 0; i < DIM; i++) qv[i] = rnd_comp();
      for (int j = 0; j < LS; j++) begin
        for (int i = 0; i < DIM; i++) c_tmp[i] = rnd_comp();
        set_entry(leaf * LS + j);
      end
      run_search(leaf, 6, "bp");
      run_search(leaf, 0, "after_bp");
    end

    // Reset in cycle 4 of a search
    setup_exact_match();
    for (int i = 0; i < DIM; i++) query_patch[DW*i +: DW] = qv[i][DW-1:0];
    leaf_index = 8'd59;
    leaf_en    = 1'b1;
    result_ready = 1'b1;
    step();
    leaf_en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b0;
    step();
    check_zero_outputs("midrst");
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("midrst_no_rv", result_valid, 0);
    end
    run_search(59, 0, "post_rst");

    // Random searches: near-duplicate candidates exercise the comparator
    for (int t = 0; t < 6; t++) begin
      int leaf;
      leaf = int'($urandom_range(0, 255));
      for (int i = 0; i < DIM; i++) qv[i] = rnd_comp();
      for (int j = 0; j < LS; j++) begin
        for (int i = 0; i < DIM; i++) begin
          if (t < 3) c_tmp[i] = rnd_comp();
          else       c_tmp[i] = qv[i] + int'($urandom_range(0, 6)) - 3;
          if (c_tmp[i] > 1023)  c_tmp[i] = 1023;
          if (c_tmp[i] < -1024) c_tmp[i] = -1024;
        end
        set_entry(leaf * LS + j);
      end
      run_search(leaf, int'($urandom_range(0, 3)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/leaf_nn_search.md
Name: leaf_nn_search

Overview:
- Downstream consumer of internal_node_tree.
- On each leaf hit (receiver_en + leaf_index), stores the query patch and reads all candidate patches of that leaf from the leaf patch memory, one per cycle.
- Computes the squared L2 distance of each candidate to the query and keeps the best (nearest) candidate.
- Presents the best distance and best patch address through a valid/ready result port to the match-collection stage.

Parameters:
DATA_WIDTH, 11, width of one signed patch component
DIM, 5, components per patch
PATCH_WIDTH, 55, DATA_WIDTH*DIM
ADDRESS_WIDTH, 8, leaf index width
LEAF_SIZE, 8, candidate patches per leaf (power of two)
IDX_WIDTH, 3, log2(LEAF_SIZE)
DIST_WIDTH, 25, squared distance width

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
leaf_en  in  1  request strobe from internal_node_tree receiver_en
leaf_index  in  ADDRESS_WIDTH  leaf selected by tree
query_patch  in  PATCH_WIDTH  query patch accompanying leaf_en
busy  out  1  high whenever state != IDLE
mem_ren  out  1  leaf memory read enable
mem_addr  out  ADDRESS_WIDTH+IDX_WIDTH  {leaf_index, candidate j}
mem_rdata  in  PATCH_WIDTH  candidate patch, valid 1 cycle after mem_ren
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
best_dist  out  DIST_WIDTH  minimum squared distance
best_addr  out  ADDRESS_WIDTH+IDX_WIDTH  memory address of best candidate

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset: state IDLE. busy, mem_ren, mem_addr, result_valid, best_dist and best_addr are all 0. Pipeline valid bits are cleared.
- Packing: component i occupies bits [11i+10:11i] and is two's complement.
- Arithmetic:
  - diff_i = q_i - c_i, sign-extended to 12 bits (range ±2047).
  - sq_i = diff_i^2, unsigned, 22 bits.
  - dist = sum of the DIM sq_i, unsigned, 25 bits (maximum 20,951,045). No saturation is needed.
- IDLE:
  - leaf_en=1 at an edge latches leaf_index and query_patch, clears candidate counter j, and moves to FETCH.
  - leaf_en is ignored in every other state; upstream must observe busy.
- FETCH:
  - mem_ren=1 and mem_addr={leaf_index_q, j} for exactly LEAF_SIZE consecutive cycles, with j incrementing 0..LEAF_SIZE-1.
  - After the last issue, move to DRAIN. mem_ren is 0 outside FETCH.
- Pipeline:
  - Stage A: in the cycle mem_rdata is valid, compute dist and register it together with j and a valid bit.
  - Stage B: in the next cycle, compare and update the best registers.
  - Candidate j=0 loads best unconditionally. Later candidates replace best only if dist < best_dist (strict), so ties keep the lowest j.
- DRAIN: wait until stage B has processed candidate LEAF_SIZE-1, then move to RESULT.
- Latency: with leaf_en accepted at edge 0, mem_ren is high in cycles 1..LEAF_SIZE and result_valid rises in cycle LEAF_SIZE+3 (cycle 11 for the defaults).
- RESULT:
  - result_valid=1. best_dist and best_addr are held stable.
  - An edge with result_ready=1 completes the transfer: result_valid drops next cycle and the state returns to IDLE.
  - If result_ready is already high when result_valid rises, the transfer completes at the first edge.
  - leaf_en during RESULT, including the handshake cycle, is ignored.
- best_dist and best_addr keep their last values in IDLE and are only overwritten by the next search.
- Reset mid-operation: any state returns to IDLE at the reset edge. In-flight reads are discarded, no result_valid is produced, and all outputs go to 0.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n=0 for 3 cycles with leaf_en=1.
   - Required response: busy=0, mem_ren=0, result_valid=0, best_dist=0, best_addr=0, and no request is accepted.
2. Exact match:
   - Stimulus: leaf_index=59, query [251,-26,-1,-88,79]. Memory entry j=3 equals the query; all other entries differ by +5 in component 0.
   - Required response:
     - mem_ren in cycles 1..8 with mem_addr 472..479.
     - result_valid in cycle 11 with best_dist=0 and best_addr=475.
     - result_ready held high, so result_valid drops in cycle 12.
3. Extremes and tie:
   - Stimulus: query all -1024, all 8 entries all +1023.
   - Required response: best_dist=20,951,045, with best_addr pointing at j=0.
4. Tie ordering:
   - Stimulus: leaf 5. Entries j=2 and j=5 differ from the query by 2 in a single component; all other entries differ by 10.
   - Required response: best_dist=4, best_addr=42.
5. Backpressure:
   - Stimulus: result_ready=0 for 6 cycles after result_valid rises, with leaf_en pulsed meanwhile.
   - Required response:
     - While result_ready=0: outputs stay stable, busy=1, mem_ren=0, and the pulse is ignored.
     - After result_ready=1: IDLE is reached, and the next leaf_en starts a correct new search.
6. Reset mid-FETCH:
   - Stimulus: assert rst_n=0 in cycle 4 of a search, then start a new search with the same stimulus as scenario 2.
   - Required response: no result_valid from the aborted search; the new search returns best_dist=0, best_addr=475.
